assert_ctrl_hub: RTL
====================

// Module: assert_ctrl_hub
// PURPOSE
//  Hardware assertion-control hub for N checker channels: per-channel runtime on/off (asserton/assertoff
//  equivalent), global kill, saturating failure counters, throttled failure reports via valid/ready FIFO.
//  Sits between in-design checker logic and a debug/log sink; replaces ad-hoc per-instance enable wires.
// PARAMETERS
//  N_CHAN      8   number of checker channels (1..32)
//  CNT_W       16  per-channel failure counter width (saturating)
//  TS_W        32  internal timestamp width (free-running, wraps)
//  MAX_RPT     4   max reports per channel between clears; 0 = unlimited
//  FIFO_DEPTH  4   report FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1              clock
//  rst         in   1              asynchronous reset, active-high
//  chk_valid   in   N_CHAN         channel attempt this cycle
//  chk_pass    in   N_CHAN         attempt result (1 = pass); ignored when chk_valid=0
//  ctrl_valid  in   1              control command strobe
//  ctrl_op     in   2              OFF=0, ON=1, KILL=2, CLR=3
//  ctrl_mask   in   N_CHAN         channels targeted by command (KILL ignores mask)
//  en_vec      out  N_CHAN         current per-channel enables
//  fail_vec    out  N_CHAN         sticky "failed since last CLR" per channel
//  fail_cnt    out  N_CHAN*CNT_W   packed counters, channel i at [i*CNT_W +: CNT_W]
//  rpt_valid   out  1              report available
//  rpt_ready   in   1              sink accepts report
//  rpt_chan    out  $clog2(N_CHAN) failing channel index (min width 1)
//  rpt_time    out  TS_W           timestamp of the failing attempt
//  rpt_count   out  CNT_W          channel counter value including this failure
// BEHAVIOUR
//  - Reset: en_vec=all 1s, fail_vec=0, fail_cnt=0, timestamp=0, pending=0, FIFO empty, rpt_valid=0.
//  - Timestamp increments every cycle, wraps to 0 after 2^TS_W-1.
//  - Failure on channel i = chk_valid[i] & ~chk_pass[i] & en_vec[i]. Disabled channel: no count, no report.
//  - Control takes effect next cycle; attempts in the command cycle use old enables.
//    OFF: en&=~mask. ON: en|=mask. KILL: en=0, FIFO flushed, all pending cleared.
//    CLR: for masked channels fail_cnt=0, fail_vec=0, report quota=0, pending cleared; en unchanged.
//  - Failure and CLR on same channel in same cycle: CLR wins (result 0); failure discarded.
//  - On failure: fail_cnt+1 saturating at 2^CNT_W-1; fail_vec set. If quota<MAX_RPT (or MAX_RPT=0) and
//    pending[i]=0: pending[i] set, capture {time,count}, quota+1. If pending[i]=1: count only,
//    no new report (coalesced); captured entry not updated.
//  - Enqueue: one pending channel per cycle, lowest index first, when FIFO not full; pending bit clears
//    on enqueue. FIFO full: pending holds; no report lost except by coalescing.
//  - Report handshake: rpt_* registered FIFO head, stable while rpt_valid & ~rpt_ready; pop on
//    valid & ready. Push and pop same cycle when full is legal. Latency failure->rpt_valid: 2 cycles
//    (pending then FIFO) when FIFO empty and channel is lowest pending.
//  - Reset mid-operation: all state returns to reset values immediately (async); no partial reports.
// STRUCTURE
//  - Package assert_ctrl_pkg: ctrl_op_e enum (OFF/ON/KILL/CLR), rpt_t struct {chan, time, count},
//    chan-index width function.
//  - Sub-module assert_rpt_fifo: synchronous FIFO of rpt_t, DEPTH param, push/pop/flush/full/empty,
//    async active-high reset. Hub holds enables, counters, quota, pending, priority select.
// TESTING
//  - Reset then chk_valid=0x01, chk_pass=0x00 -> 2 cycles later rpt_valid=1, rpt_chan=0, rpt_count=1.
//  - OFF mask=0x02 then fail ch1 x3 -> fail_cnt[1]=0, no report; ON 0x02 then fail -> report, count=1.
//  - ch2 fails 6 times, MAX_RPT=4, rpt_ready=1 -> exactly 4 reports, fail_cnt[2]=6; CLR 0x04 -> count 0, new report.
//  - chk_valid=0xFF, chk_pass=0x00, rpt_ready=0 -> FIFO fills ch0..3, ch4..7 pending; ready=1 -> order 0..7.
//  - CNT_W=2, ch3 fails 5 times -> fail_cnt[3]=3 held; fail + CLR same cycle on ch3 -> counter 0.
//  - FIFO holding 3 entries, KILL -> rpt_valid=0 next cycle, en_vec=0; rst pulse mid-burst -> reset values.

Source files
------------

// File: rtl/assert_ctrl_pkg.sv
// Shared types for the assertion-control hub: control opcodes, the report
// record and the channel-index width helper.
package assert_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_OFF  = 2'd0,
      OP_ON   = 2'd1,
      OP_KILL = 2'd2,
      OP_CLR  = 2'd3
   } ctrl_op_e;

   // Default report field widths (8 channels, 32-bit time, 16-bit counters).
   localparam int DEF_CHAN_W = 3;
   localparam int DEF_TS_W   = 32;
   localparam int DEF_CNT_W  = 16;

   // One failure report; the hub re-declares it at its own parameter widths.
   typedef struct packed {
      logic [DEF_CHAN_W-1:0] chan;
      logic [DEF_TS_W-1:0]   ts;
      logic [DEF_CNT_W-1:0]  count;
   } rpt_t;

   // Channel index width, never below one bit.
   function automatic int chan_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/assert_rpt_fifo.sv
// Small synchronous FIFO of report records. Head is read straight out of the
// storage registers, so it only changes on a pop, push-into-empty or flush.
// A push while full is accepted only when a pop happens in the same cycle.
module assert_rpt_fifo
   import assert_ctrl_pkg::*;
#(
   parameter type T     = rpt_t,
   parameter int  DEPTH = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push_i,
   input  logic pop_i,
   input  logic flush_i,
   input  T     data_i,
   output T     head_o,
   output logic full_o,
   output logic empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   T            mem_q [DEPTH];
   logic [AW:0] wr_q;
   logic [AW:0] rd_q;
   logic        do_push;
   logic        do_pop;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);
   assign head_o  = mem_q[rd_q[AW-1:0]];

   // Storage and pointer update; flush empties without touching storage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_q <= '0;
         rd_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (flush_i) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
            wr_q                <= wr_q + PTR_ONE;
         end
         if (do_pop) rd_q <= rd_q + PTR_ONE;
      end
   end

endmodule

// File: rtl/assert_ctrl_hub.sv
// Assertion-control hub: per-channel enables, global kill, saturating failure
// counters, per-channel report quota and a one-deep pending slot per channel
// that drains into the report FIFO lowest channel first.
//
// Report handshake: rpt_valid_o/rpt_chan_o/rpt_time_o/rpt_count_o come from the
// FIFO head and hold steady while rpt_valid_o & ~rpt_ready_i; a report is
// consumed on any cycle with rpt_valid_o & rpt_ready_i.
module assert_ctrl_hub
   import assert_ctrl_pkg::*;
#(
   parameter int N_CHAN     = 8,
   parameter int CNT_W      = 16,
   parameter int TS_W       = 32,
   parameter int MAX_RPT    = 4,
   parameter int FIFO_DEPTH = 4,
   localparam int CW = chan_w(N_CHAN)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [N_CHAN-1:0]       chk_valid_i,
   input  logic [N_CHAN-1:0]       chk_pass_i,
   input  logic                    ctrl_valid_i,
   input  logic [1:0]              ctrl_op_i,
   input  logic [N_CHAN-1:0]       ctrl_mask_i,
   output logic [N_CHAN-1:0]       en_vec_o,
   output logic [N_CHAN-1:0]       fail_vec_o,
   output logic [N_CHAN*CNT_W-1:0] fail_cnt_o,
   output logic                    rpt_valid_o,
   input  logic                    rpt_ready_i,
   output logic [CW-1:0]           rpt_chan_o,
   output logic [TS_W-1:0]         rpt_time_o,
   output logic [CNT_W-1:0]        rpt_count_o
);

   localparam int QW = (MAX_RPT > 0) ? $clog2(MAX_RPT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   typedef struct packed {
      logic [CW-1:0]    chan;
      logic [TS_W-1:0]  ts;
      logic [CNT_W-1:0] count;
   } hub_rpt_t;

   ctrl_op_e          op;
   logic [TS_W-1:0]   ts_q;
   logic [N_CHAN-1:0] en_q, en_d, fvec_q, fvec_d, pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q [N_CHAN];
   logic [CNT_W-1:0]  cnt_d [N_CHAN];
   logic [CNT_W-1:0]  cap_cnt_q [N_CHAN];
   logic [CNT_W-1:0]  cap_cnt_d [N_CHAN];
   logic [TS_W-1:0]   cap_ts_q [N_CHAN];
   logic [TS_W-1:0]   cap_ts_d [N_CHAN];
   logic [QW-1:0]     quota_q [N_CHAN];
   logic [QW-1:0]     quota_d [N_CHAN];

   logic              kill;
   logic [N_CHAN-1:0] clr_m, fail_m, cand;
   logic              sel_hit, push;
   logic [CW-1:0]     sel_idx;
   hub_rpt_t          push_data, head;
   logic              fifo_full, fifo_empty, fifo_pop;

   assign op          = ctrl_op_e'(ctrl_op_i);
   assign rpt_valid_o = ~fifo_empty;
   assign fifo_pop    = rpt_valid_o & rpt_ready_i;
   assign rpt_chan_o  = head.chan;
   assign rpt_time_o  = head.ts;
   assign rpt_count_o = head.count;
   assign en_vec_o    = en_q;
   assign fail_vec_o  = fvec_q;

   // Next-state: enqueue selection, clear/failure bookkeeping, enable update.
   always_comb begin
      kill    = ctrl_valid_i && (op == OP_KILL);
      clr_m   = (ctrl_valid_i && (op == OP_CLR)) ? ctrl_mask_i : '0;
      fail_m  = chk_valid_i & ~chk_pass_i & en_q;
      // A channel being cleared this cycle loses its pending report.
      cand    = pend_q & ~clr_m;
      sel_hit = 1'b0;
      sel_idx = '0;
      for (int i = N_CHAN - 1; i >= 0; i--) begin
         if (cand[i]) begin
            sel_hit = 1'b1;
            sel_idx = CW'(i);
         end
      end
      push            = sel_hit & ~kill & (~fifo_full | fifo_pop);
      push_data.chan  = sel_idx;
      push_data.ts    = cap_ts_q[sel_idx];
      push_data.count = cap_cnt_q[sel_idx];

      en_d      = en_q;
      fvec_d    = fvec_q;
      pend_d    = pend_q;
      cnt_d     = cnt_q;
      quota_d   = quota_q;
      cap_ts_d  = cap_ts_q;
      cap_cnt_d = cap_cnt_q;

      if (push) pend_d[sel_idx] = 1'b0;
      if (kill) pend_d = '0;

      // The slot freed by this cycle's enqueue can take a new failure at once.
      for (int i = 0; i < N_CHAN; i++) begin
         if (clr_m[i]) begin
            cnt_d[i]   = '0;
            fvec_d[i]  = 1'b0;
            quota_d[i] = '0;
            pend_d[i]  = 1'b0;
         end else if (fail_m[i]) begin
            cnt_d[i]  = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
            fvec_d[i] = 1'b1;
            if (!kill && !pend_d[i] &&
                ((MAX_RPT == 0) || (quota_q[i] < QW'(MAX_RPT)))) begin
               pend_d[i]    = 1'b1;
               cap_ts_d[i]  = ts_q;
               cap_cnt_d[i] = cnt_d[i];
               if (MAX_RPT != 0) quota_d[i] = quota_q[i] + QW'(1);
            end
         end
      end

      if (ctrl_valid_i) begin
         case (op)
            OP_OFF:  en_d = en_q & ~ctrl_mask_i;
            OP_ON:   en_d = en_q | ctrl_mask_i;
            OP_KILL: en_d = '0;
            default: en_d = en_q;
         endcase
      end
   end

   // State registers; the timestamp free-runs and wraps.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ts_q   <= '0;
         en_q   <= '1;
         fvec_q <= '0;
         pend_q <= '0;
         for (int i = 0; i < N_CHAN; i++) begin
            cnt_q[i]     <= '0;
            quota_q[i]   <= '0;
            cap_ts_q[i]  <= '0;
            cap_cnt_q[i] <= '0;
         end
      end else begin
         ts_q      <= ts_q + TS_W'(1);
         en_q      <= en_d;
         fvec_q    <= fvec_d;
         pend_q    <= pend_d;
         cnt_q     <= cnt_d;
         quota_q   <= quota_d;
         cap_ts_q  <= cap_ts_d;
         cap_cnt_q <= cap_cnt_d;
      end
   end

   // Pack the per-channel counters onto the flat output bus.
   always_comb begin
      fail_cnt_o = '0;
      for (int i = 0; i < N_CHAN; i++) fail_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
   end

   assert_rpt_fifo #(
      .T     (hub_rpt_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (push),
      .pop_i   (fifo_pop),
      .flush_i (kill),
      .data_i  (push_data),
      .head_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule
